mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
- Parametrised, registered N-to-1 multiplexer of WIDTH-bit channels; successor to the fixed 4-to-1 combinational muxes.
- Two modes: manual (channel chosen by `sel`) and auto-scan (an internal round-robin channel counter with a programmable dwell time per channel).
- Used to time-share N sensor/data lanes onto one output bus, e.g. for display scanning or a serial front-end.

Parameters:
- WIDTH, 4, bits per channel.
- N, 4, number of channels (2..16).
- SEL_W, 2, select/counter width; must satisfy 2**SEL_W >= N.
- DWELL, 4, clock-enable cycles spent on each channel in auto mode (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; all state advances only when en=1.
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SEL_W  manual channel select.
- in  input  N*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH].
- out  output  WIDTH  registered selected channel data.
- out_ch  output  SEL_W  registered index of the channel currently on `out`.
- out_valid  output  1  registered; 1 when `out` holds a valid sample taken in the previous cycle.

Behaviour:
- Reset (rst=1 at a clk edge, overrides en and all other inputs):
  - out=0, out_ch=0, out_valid=0.
  - state=MAN, ch=0, dc=0.
- Latency: one cycle. A sample taken at edge t appears on out/out_ch/out_valid after edge t.
- State machine, two states (MAN, AUTO). The path used at a given edge is decided by the *current* state, not by `mode`.
- MAN state, en=1:
  - sel < N: out<=in[sel], out_ch<=sel, out_valid<=1.
  - sel >= N: out<=0, out_ch<=sel, out_valid<=0.
  - If mode=1: state<=AUTO, ch<=0, dc<=0. The output at this edge still follows the manual path.
- AUTO state, en=1:
  - out<=in[ch], out_ch<=ch, out_valid<=1.
  - If dc==DWELL-1: dc<=0, and ch<=0 when ch==N-1, else ch+1.
  - Otherwise dc<=dc+1.
  - If mode=0: state<=MAN. The output at this edge still follows the auto path; ch and dc still update as above but are reset to 0 on the next entry into AUTO.
- en=0 (any state): out and out_ch hold; out_valid<=0; state, ch and dc hold; mode changes are ignored.
- DWELL=1: ch advances on every enabled cycle.
- Wrap: ch goes N-1 -> 0. ch never reaches a value >= N, even when N < 2**SEL_W.
- Reset mid-scan: the next enabled cycle after reset samples in the manual path (state=MAN). A scan always restarts from channel 0.
- Arithmetic: ch and dc are unsigned. dc has width $clog2(DWELL) (minimum 1 bit) and never exceeds DWELL-1.
- No combinational path from any input to any output.

Test Plan:
- All scenarios use N=4, WIDTH=4, DWELL=4 and in = {4'hD,4'hC,4'hB,4'hA}, so channel 0 = A.
- Reset: hold rst=1 for 2 cycles with en=1, mode=1 -> out=0, out_ch=0, out_valid=0. After release, the first enabled edge takes the manual path.
- Manual sweep: mode=0, en=1, sel=0,1,2,3 on consecutive edges -> out=A,B,C,D and out_ch=0..3, each one cycle after its sel, out_valid=1.
- Auto scan: mode=1 held for 20 enabled cycles.
  - Edge 1 takes the manual path (state transition).
  - Then out=A for 4 cycles, B x4, C x4, D x4, then A again (wrap); out_ch tracks the channel.
- Enable gating: in auto mode, drop en for 3 cycles mid-dwell on B (dc=2).
  - During the gap: out stays B and out_valid=0.
  - After en returns: B continues for exactly 2 more cycles, then C.
- Mode flip and out-of-range:
  - Auto on C, then mode=0 with sel=1 -> one more C sample, then B.
  - With sel held at 1, set mode=1 -> one B, then scan restarts at A.
  - Separately, N=3 with sel=3 -> out=0, out_valid=0.
- Reset mid-scan: assert rst for 1 cycle while out=D.
  - Outputs go to 0 after that edge.
  - With mode=1, the scan resumes A after the manual transition cycle.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N-to-1 channel multiplexer.
// Manual mode forwards the channel picked by sel. Auto-scan mode walks the
// channels round-robin and stays DWELL enabled cycles on each one.
module mux_nto1_scan #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N*WIDTH-1:0]   in,
  output logic [WIDTH-1:0]     out,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid
);

  // The dwell counter needs at least one bit, even when DWELL is 1.
  localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MAN  = 1'b0,
    AUTO = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [DC_W-1:0]    dc_q, dc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   man_data;
  logic [WIDTH-1:0]   auto_data;
  logic               sel_ok;

  // Channel lookup for both paths; sel_ok is set only when sel names a real channel.
  always_comb begin
    man_data  = '0;
    auto_data = '0;
    sel_ok    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        man_data = in[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
      if (ch_q == SEL_W'(k)) begin
        auto_data = in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and next outputs; the current state, not mode, picks the path.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dc_d        = dc_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    if (en) begin
      unique case (state_q)
        MAN: begin
          out_ch_d = sel;
          if (sel_ok) begin
            out_d       = man_data;
            out_valid_d = 1'b1;
          end else begin
            out_d       = '0;
          end
          // Entering auto always restarts the scan from channel 0.
          if (mode) begin
            state_d = AUTO;
            ch_d    = '0;
            dc_d    = '0;
          end
        end
        AUTO: begin
          out_d       = auto_data;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          if (dc_q == DC_W'(DWELL - 1)) begin
            dc_d = '0;
            ch_d = (ch_q == SEL_W'(N - 1)) ? '0 : ch_q + SEL_W'(1);
          end else begin
            dc_d = dc_q + DC_W'(1);
          end
          if (!mode) begin
            state_d = MAN;
          end
        end
        default: begin
          state_d = MAN;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MAN;
      ch_q        <= '0;
      dc_q        <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dc_q        <= dc_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan: scoreboard of expected samples plus
// hand-derived channel checks at the interesting points of each scenario.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [1:0]  sel;
  logic [15:0] in4 = 16'hDCBA;
  logic [11:0] in3 = 12'hCBA;
  logic [3:0]  out4, out3;
  logic [1:0]  out_ch4, out_ch3;
  logic        out_valid4, out_valid3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] o;
    logic [1:0] c;
    logic       v;
  } exp_t;
  exp_t exp_q[$];

  // Reference state for the N=4 instance.
  int         m_state = 0;
  int         m_ch = 0;
  int         m_dc = 0;
  logic [3:0] m_out = '0;
  logic [1:0] m_och = '0;
  logic       m_vld = 1'b0;

  logic [3:0] chan_v [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  always #5 clk = ~clk;

  mux_nto1_scan #(.WIDTH(4), .N(4), .SEL_W(2), .DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .in(in4),
    .out(out4), .out_ch(out_ch4), .out_valid(out_valid4)
  );

  mux_nto1_scan #(.WIDTH(4), .N(3), .SEL_W(2), .DWELL(4)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .in(in3),
    .out(out3), .out_ch(out_ch3), .out_valid(out_valid3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference by one edge given the inputs about to be applied.
  task automatic model_edge(input bit r, input bit e, input bit m, input logic [1:0] s);
    if (r) begin
      m_state = 0; m_ch = 0; m_dc = 0; m_out = '0; m_och = '0; m_vld = 1'b0;
    end else if (!e) begin
      m_vld = 1'b0;
    end else if (m_state == 0) begin
      m_och = s;
      m_out = chan_v[s];
      m_vld = 1'b1;
      if (m) begin m_state = 1; m_ch = 0; m_dc = 0; end
    end else begin
      m_out = chan_v[m_ch];
      m_och = 2'(m_ch);
      m_vld = 1'b1;
      if (m_dc == 3) begin
        m_dc = 0;
        m_ch = (m_ch == 3) ? 0 : m_ch + 1;
      end else begin
        m_dc = m_dc + 1;
      end
      if (!m) m_state = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit m, input logic [1:0] s);
    exp_t x;
    rst = r; en = e; mode = m; sel = s;
    model_edge(r, e, m, s);
    exp_q.push_back('{o: m_out, c: m_och, v: m_vld});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check("sb_out", 32'(out4), 32'(x.o));
      check("sb_ch", 32'(out_ch4), 32'(x.c));
      check("sb_vld", 32'(out_valid4), 32'(x.v));
    end
  endtask

  initial begin
    int guard;
    // Reset held two cycles with auto requested.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    check("rst_out", 32'(out4), 32'h0);
    check("rst_ch", 32'(out_ch4), 32'h0);
    check("rst_vld", 32'(out_valid4), 32'h0);

    // Manual sweep.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 2'(i));
      check("man_out", 32'(out4), 32'(chan_v[i]));
      check("man_ch", 32'(out_ch4), 32'(i));
    end

    // Auto scan: edge 0 is the manual transition, then 4 cycles per channel.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0);
      if (i == 0) check("auto_first", 32'(out4), 32'hA);
      else begin
        check("auto_out", 32'(out4), 32'(chan_v[((i - 1) / 4) % 4]));
        check("auto_ch", 32'(out_ch4), 32'(((i - 1) / 4) % 4));
      end
    end

    // Enable gating mid-dwell on B.
    step(0, 1, 1, 0);
    check("gate_lastA", 32'(out4), 32'hA);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    check("gate_B2", 32'(out4), 32'hB);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      check("gap_out", 32'(out4), 32'hB);
      check("gap_vld", 32'(out_valid4), 32'h0);
    end
    step(0, 1, 1, 0);
    check("resume_B3", 32'(out4), 32'hB);
    step(0, 1, 1, 0);
    check("resume_B4", 32'(out4), 32'hB);
    step(0, 1, 1, 0);
    check("resume_C", 32'(out4), 32'hC);

    // Mode flip back to manual and into auto again.
    step(0, 1, 0, 1);
    check("flip_C", 32'(out4), 32'hC);
    step(0, 1, 0, 1);
    check("flip_B", 32'(out4), 32'hB);
    step(0, 1, 1, 1);
    check("reenter_B", 32'(out4), 32'hB);
    step(0, 1, 1, 1);
    check("restart_A", 32'(out4), 32'hA);
    check("restart_ch", 32'(out_ch4), 32'h0);

    // Run the scan until D is on the output, then reset mid-scan.
    guard = 0;
    while (out4 !== 4'hD && guard < 40) begin
      step(0, 1, 1, 0);
      guard++;
    end
    check("reach_D", 32'(out4), 32'hD);
    step(1, 1, 1, 0);
    check("mid_rst_out", 32'(out4), 32'h0);
    check("mid_rst_vld", 32'(out_valid4), 32'h0);
    step(0, 1, 1, 2);
    check("post_rst_man", 32'(out4), 32'hC);
    step(0, 1, 1, 2);
    check("post_rst_A", 32'(out4), 32'hA);

    // N=3 instance: in-range and out-of-range select.
    step(1, 1, 0, 0);
    step(0, 1, 0, 2);
    check("n3_out2", 32'(out3), 32'hC);
    check("n3_vld2", 32'(out_valid3), 32'h1);
    step(0, 1, 0, 3);
    check("n3_oor_out", 32'(out3), 32'h0);
    check("n3_oor_vld", 32'(out_valid3), 32'h0);
    check("n3_oor_ch", 32'(out_ch3), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
